sha2_pad: RTL and testbench

Front-end message formatter for the SHA-2 datapath. It accepts an arbitrary-length message as a 64-bit AXI4-Stream and applies FIPS 180-4 padding: 0x80 marker, zero fill and a big-endian bit-length field. It emits complete 512-bit (SHA-224/256) or 1024-bit (SHA-384/512) message blocks as 512-bit AXI4-Stream beats to the compression core. It sits at the opposite end of the pipeline from the digest output stage and uses the same TUSER SHA-type encoding.

---
 rtl/sha2_pad.sv | 220 ++++++++++++++++++++++
 tb/tb_sha2_pad.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_pad.sv
// SHA-2 message padder: packs a 64-bit byte stream into FIPS 180-4 padded
// 512/1024-bit blocks and streams them out as 512-bit beats.
module sha2_pad #(
    parameter int unsigned S_AXIS_DATA_WIDTH  = 64,
    parameter int unsigned M_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned M_AXIS_TUSER_WIDTH = 128
) (
    input  logic                            axi_aclk,
    input  logic                            reset,
    input  logic [S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready
);

    localparam int unsigned LANES     = S_AXIS_DATA_WIDTH / 8;
    localparam int unsigned BLK_BYTES = 128;
    localparam int unsigned BLK_W     = BLK_BYTES * 8;
    localparam int unsigned CNT_W     = 61;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_EMIT,
        ST_PADBLK
    } state_t;

    state_t                          state_q;
    logic [BLK_W-1:0]                blk_q;
    logic [6:0]                      ptr_q;
    logic [CNT_W-1:0]                cnt_q;
    logic                            in_msg_q;
    logic                            big_q;
    logic                            final_q;
    logic                            pad_pend_q;
    logic                            m80_q;
    logic                            beat_q;
    logic [S_AXIS_TUSER_WIDTH-1:0]   tuser_q;

    logic                            hs_c;
    logic                            first_c;
    logic                            big_c;
    logic                            final_c;
    logic                            go_emit_c;
    logic [3:0]                      n_c;
    logic [7:0]                      p_c;
    logic [7:0]                      blen_c;
    logic [6:0]                      lane_idx_c;
    logic [CNT_W-1:0]                cnt_new_c;
    logic [BLK_W-1:0]                blk_fill_c;
    logic [BLK_W-1:0]                blk_pad_c;

    // Big-endian bit length into the block tail; for 1024-bit blocks the
    // upper 64 bits of the 128-bit length field are zero.
    function automatic logic [BLK_W-1:0] put_len(input logic [BLK_W-1:0] b,
                                                 input logic big,
                                                 input logic [CNT_W-1:0] c);
        logic [BLK_W-1:0] r;
        logic [63:0]      bits;
        logic [63:0]      rev;
        r    = b;
        bits = {c, 3'b000};
        rev  = '0;
        for (int j = 0; j < 8; j++) begin
            rev[8*j +: 8] = bits[8*(7-j) +: 8];
        end
        if (big) begin
            r[1023:960] = rev;
            r[959:896]  = '0;
        end else begin
            r[511:448]  = rev;
        end
        return r;
    endfunction

    // Next block image for an accepted input beat, and the extra pad block
    always_comb begin
        hs_c       = s_axis_tvalid && s_axis_tready;
        first_c    = !in_msg_q;
        big_c      = first_c ? s_axis_tuser[33] : big_q;
        n_c        = '0;
        lane_idx_c = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            n_c = n_c + 4'(s_axis_tkeep[k]);
        end
        p_c        = 8'(ptr_q) + 8'(n_c);
        blen_c     = big_c ? 8'd128 : 8'd64;
        cnt_new_c  = cnt_q + CNT_W'(n_c);
        final_c    = s_axis_tlast && (p_c <= (big_c ? 8'd111 : 8'd55));
        go_emit_c  = s_axis_tlast || (p_c == blen_c);

        blk_fill_c = blk_q;
        for (int k = 0; k < int'(LANES); k++) begin
            lane_idx_c = ptr_q + 7'(k);
            if (s_axis_tkeep[k]) begin
                blk_fill_c[{lane_idx_c, 3'b000} +: 8] = s_axis_tdata[8*k +: 8];
            end
        end
        if (s_axis_tlast) begin
            for (int i = 0; i < int'(BLK_BYTES); i++) begin
                if (8'(i) < blen_c && 8'(i) == p_c) begin
                    blk_fill_c[8*i +: 8] = 8'h80;
                end else if (8'(i) < blen_c && 8'(i) > p_c) begin
                    blk_fill_c[8*i +: 8] = 8'h00;
                end
            end
        end
        if (final_c) begin
            blk_fill_c = put_len(blk_fill_c, big_c, cnt_new_c);
        end

        blk_pad_c = '0;
        if (m80_q) begin
            blk_pad_c[7:0] = 8'h80;
        end
        blk_pad_c = put_len(blk_pad_c, big_q, cnt_q);
    end

    // Control FSM and registered outputs
    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_FILL;
            blk_q         <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            in_msg_q      <= 1'b0;
            big_q         <= 1'b0;
            final_q       <= 1'b0;
            pad_pend_q    <= 1'b0;
            m80_q         <= 1'b0;
            beat_q        <= 1'b0;
            tuser_q       <= '0;
            s_axis_tready <= 1'b1;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tkeep  <= '1;
        end else begin
            m_axis_tkeep <= '1;
            case (state_q)
                ST_FILL: begin
                    if (hs_c) begin
                        blk_q    <= blk_fill_c;
                        cnt_q    <= cnt_new_c;
                        in_msg_q <= 1'b1;
                        if (first_c) begin
                            tuser_q <= s_axis_tuser;
                            big_q   <= big_c;
                        end
                        if (go_emit_c) begin
                            state_q       <= ST_EMIT;
                            s_axis_tready <= 1'b0;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= blk_fill_c[511:0];
                            m_axis_tuser  <= first_c ? s_axis_tuser : tuser_q;
                            m_axis_tlast  <= final_c && !big_c;
                            final_q       <= final_c;
                            pad_pend_q    <= s_axis_tlast && !final_c;
                            m80_q         <= s_axis_tlast && (p_c == blen_c);
                            beat_q        <= 1'b0;
                            ptr_q         <= '0;
                        end else begin
                            ptr_q <= p_c[6:0];
                        end
                    end
                end
                ST_EMIT: begin
                    if (m_axis_tready) begin
                        if (big_q && !beat_q) begin
                            beat_q       <= 1'b1;
                            m_axis_tdata <= blk_q[1023:512];
                            m_axis_tlast <= final_q;
                        end else begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            blk_q         <= '0;
                            ptr_q         <= '0;
                            beat_q        <= 1'b0;
                            if (!final_q && pad_pend_q) begin
                                state_q <= ST_PADBLK;
                            end else begin
                                state_q       <= ST_FILL;
                                s_axis_tready <= 1'b1;
                                if (final_q) begin
                                    cnt_q      <= '0;
                                    in_msg_q   <= 1'b0;
                                    final_q    <= 1'b0;
                                    pad_pend_q <= 1'b0;
                                    m80_q      <= 1'b0;
                                end
                            end
                        end
                    end
                end
                ST_PADBLK: begin
                    blk_q         <= blk_pad_c;
                    state_q       <= ST_EMIT;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= blk_pad_c[511:0];
                    m_axis_tlast  <= !big_q;
                    final_q       <= 1'b1;
                    pad_pend_q    <= 1'b0;
                    m80_q         <= 1'b0;
                    beat_q        <= 1'b0;
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_pad.sv
// Scoreboard bench for sha2_pad: a FIPS 180-4 padding model predicts every
// output beat; scenario tasks add timing and reset checks.
module tb_sha2_pad;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [511:0] data;
        logic         last;
        logic [127:0] user;
    } beat_t;

    logic         axi_aclk = 1'b0;
    logic         reset;
    logic [63:0]  s_axis_tdata;
    logic [7:0]   s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;

    beat_t        exp_q[$];
    beat_t        mon_e;
    int           checks   = 0;
    int           failures = 0;
    int           n_out    = 0;
    logic [511:0] last_data;
    bit           bp_en    = 1'b0;

    sha2_pad dut (
        .axi_aclk      (axi_aclk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 axi_aclk = ~axi_aclk;

    always @(posedge axi_aclk) begin
        #1;
        if (bp_en) m_axis_tready = ($urandom_range(0, 3) != 0);
    end

    // Scoreboard: compare each output handshake against the predicted beat
    always @(negedge axi_aclk) begin
        if (!reset && m_axis_tvalid && m_axis_tready) begin
            checks++;
            last_data = m_axis_tdata;
            n_out++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat got data=%h last=%b", m_axis_tdata, m_axis_tlast);
            end else begin
                mon_e = exp_q.pop_front();
                if (m_axis_tdata !== mon_e.data || m_axis_tlast !== mon_e.last ||
                    m_axis_tuser !== mon_e.user || m_axis_tkeep !== {64{1'b1}}) begin
                    failures++;
                    $display("FAIL out_beat got data=%h last=%b user=%h keep=%h", m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_tkeep);
                    $display("     expected data=%h last=%b user=%h", mon_e.data, mon_e.last, mon_e.user);
                end
            end
        end
    end

    function automatic bq_t make_msg(input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    function automatic logic [127:0] mk_user(input logic [1:0] t);
        logic [127:0] u;
        u = {$urandom, $urandom, $urandom, $urandom};
        u[33:32] = t;
        return u;
    endfunction

    // Reference padding: msg || 80 || 00.. || length, split into 64-byte beats
    task automatic push_expected(input bq_t msg, input logic [127:0] user);
        bq_t         pm;
        int          blk;
        int          lf;
        logic [63:0] bits;
        beat_t       b;
        blk  = user[33] ? 128 : 64;
        lf   = user[33] ? 16 : 8;
        pm   = msg;
        pm.push_back(8'h80);
        while ((pm.size() % blk) != blk - lf) pm.push_back(8'h00);
        for (int i = 0; i < lf - 8; i++) pm.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) pm.push_back(bits[8*i +: 8]);
        for (int c = 0; c < pm.size() / 64; c++) begin
            b.data = '0;
            for (int i = 0; i < 64; i++) b.data[8*i +: 8] = pm[64*c + i];
            b.last = (c == pm.size() / 64 - 1);
            b.user = user;
            exp_q.push_back(b);
        end
    endtask

    // Drive a message; later beats carry junk tuser that must be ignored
    task automatic send_msg(input bq_t msg, input logic [127:0] user);
        int nb;
        int w;
        nb = (msg.size() + 7) / 8;
        if (nb == 0) nb = 1;
        for (int bi = 0; bi < nb; bi++) begin
            s_axis_tdata = '0;
            s_axis_tkeep = '0;
            for (int k = 0; k < 8; k++) begin
                if (8*bi + k < msg.size()) begin
                    s_axis_tdata[8*k +: 8] = msg[8*bi + k];
                    s_axis_tkeep[k] = 1'b1;
                end
            end
            s_axis_tuser  = (bi == 0) ? user : {$urandom, $urandom, $urandom, $urandom};
            s_axis_tlast  = (bi == nb - 1);
            s_axis_tvalid = 1'b1;
            w = 0;
            @(negedge axi_aclk);
            while (!s_axis_tready && w < 2000) begin
                @(negedge axi_aclk);
                w++;
            end
            if (w >= 2000) begin
                checks++;
                failures++;
                $display("FAIL input_stall got tready=%b expected 1", s_axis_tready);
            end
            @(posedge axi_aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 4000) begin
            @(negedge axi_aclk);
            w++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got pending=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge axi_aclk);
        @(negedge axi_aclk);
        checks++;
        if (s_axis_tready !== 1'b1 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
            m_axis_tdata !== '0 || m_axis_tuser !== '0 || m_axis_tkeep !== {64{1'b1}}) begin
            failures++;
            $display("FAIL reset_values got tready=%b tvalid=%b tlast=%b keep=%h expected 1 0 0 all-ones",
                     s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tkeep);
        end
        @(posedge axi_aclk);
        #1;
        reset = 1'b0;
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic test_abc(input logic [1:0] t);
        bq_t msg;
        logic [127:0] u;
        msg = {8'h61, 8'h62, 8'h63};
        u = mk_user(t);
        n_out = 0;
        push_expected(msg, u);
        send_msg(msg, u);
        @(negedge axi_aclk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL abc_emit_start got tvalid=%b tready=%b expected 1 0", m_axis_tvalid, s_axis_tready);
        end
        if (t[1]) begin
            @(negedge axi_aclk);
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1) begin
                failures++;
                $display("FAIL abc_second_beat got tvalid=%b tlast=%b expected 1 1", m_axis_tvalid, m_axis_tlast);
            end
        end
        @(negedge axi_aclk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL abc_back_to_fill got tvalid=%b tready=%b expected 0 1", m_axis_tvalid, s_axis_tready);
        end
        checks++;
        if (n_out != (t[1] ? 2 : 1) || last_data[511:504] !== 8'h18 ||
            (!t[1] && last_data[31:0] !== 32'h80636261)) begin
            failures++;
            $display("FAIL abc_content got beats=%0d byte63=%h head=%h expected 18 / 80636261",
                     n_out, last_data[511:504], last_data[31:0]);
        end
        drain();
    endtask

    task automatic test_empty();
        bq_t msg;
        logic [127:0] u;
        u = mk_user(2'b01);
        push_expected(msg, u);
        send_msg(msg, u);
        drain();
        checks++;
        if (last_data !== 512'h80) begin
            failures++;
            $display("FAIL empty_block got %h expected 80 in byte 0 only", last_data);
        end
    endtask

    task automatic test_len56();
        bq_t msg;
        logic [127:0] u;
        msg = make_msg(56);
        u = mk_user(2'b01);
        push_expected(msg, u);
        send_msg(msg, u);
        @(negedge axi_aclk);
        @(negedge axi_aclk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL padblk_cycle got tvalid=%b tready=%b expected 0 0", m_axis_tvalid, s_axis_tready);
        end
        @(negedge axi_aclk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1 || m_axis_tdata[511:496] !== 16'hC001) begin
            failures++;
            $display("FAIL padblk_valid got tvalid=%b tlast=%b tail=%h expected 1 1 c001",
                     m_axis_tvalid, m_axis_tlast, m_axis_tdata[511:496]);
        end
        drain();
    endtask

    task automatic test_len64();
        bq_t msg;
        logic [127:0] u;
        msg = make_msg(64);
        u = mk_user(2'b01);
        push_expected(msg, u);
        send_msg(msg, u);
        drain();
        checks++;
        if (last_data[7:0] !== 8'h80 || last_data[511:496] !== 16'h0002) begin
            failures++;
            $display("FAIL m80_block got byte0=%h tail=%h expected 80 0002", last_data[7:0], last_data[511:496]);
        end
    endtask

    task automatic test_back_to_back();
        int lens[16] = '{0, 1, 7, 8, 55, 56, 57, 63, 64, 111, 112, 119, 120, 127, 128, 200};
        bq_t msg;
        logic [127:0] u;
        bp_en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 16; i++) begin
                msg = make_msg(lens[i]);
                u = mk_user(2'(i + r));
                push_expected(msg, u);
                send_msg(msg, u);
            end
        end
        drain();
        bp_en = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_backpressure_reset();
        bq_t msg;
        logic [127:0] u;
        msg = {8'h61, 8'h62, 8'h63};
        u = mk_user(2'b01);
        m_axis_tready = 1'b0;
        push_expected(msg, u);
        send_msg(msg, u);
        for (int i = 0; i < 5; i++) begin
            @(negedge axi_aclk);
            checks++;
            if (m_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0 || m_axis_tdata !== exp_q[0].data ||
                m_axis_tlast !== 1'b1) begin
                failures++;
                $display("FAIL hold_stable cycle=%0d got tvalid=%b tready=%b tlast=%b expected 1 0 1",
                         i, m_axis_tvalid, s_axis_tready, m_axis_tlast);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0) begin
            failures++;
            $display("FAIL async_reset got tvalid=%b tready=%b tlast=%b expected 0 1 0",
                     m_axis_tvalid, s_axis_tready, m_axis_tlast);
        end
        exp_q.delete();
        @(posedge axi_aclk);
        #1;
        reset = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge axi_aclk);
        #1;
        test_abc(2'b01);
    endtask

    initial begin
        reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        test_reset();
        test_abc(2'b01);
        test_empty();
        test_len56();
        test_len64();
        test_abc(2'b11);
        test_abc(2'b00);
        test_abc(2'b10);
        test_back_to_back();
        test_backpressure_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
